// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame states and line idle level, used by the receive and transmit paths.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   localparam logic LineIdle = 1'b1;

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchroniser, glitch filter and a falling-edge strobe on the filtered level.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_level;
   logic            r_level_prev;
   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic            w_level_next;

   // r_cnt counts consecutive samples that disagree with the filtered level.
   always_comb begin
      w_cnt_next   = r_cnt;
      w_level_next = r_level;
      if (r_sync2 == r_level) begin
         w_cnt_next = '0;
      end else if (r_cnt == CntW'(FILTER_CYCLES - 1)) begin
         w_level_next = r_sync2;
         w_cnt_next   = '0;
      end else begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1      <= LineIdle;
         r_sync2      <= LineIdle;
         r_level      <= LineIdle;
         r_level_prev <= LineIdle;
         r_cnt        <= '0;
      end else begin
         r_sync1      <= i_line;
         r_sync2      <= r_sync1;
         r_level      <= w_level_next;
         r_level_prev <= r_level;
         r_cnt        <= w_cnt_next;
      end
   end

   assign o_level = r_level;
   assign o_fall  = r_level_prev & ~r_level;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver with inter-edge timeout and a one-byte ready/valid output buffer.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 54000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   input  logic       i_enable,
   input  logic       i_scan_code_ready,
   output logic       o_scan_code_valid,
   output logic [7:0] o_scan_code_byte,
   output logic       o_frame_error,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic            w_clk_level_unused;
   logic            w_clk_fall;
   logic            w_data_level;
   logic            w_data_fall_unused;

   ps2_state_e      r_state;
   ps2_state_e      w_state_next;
   logic [2:0]      r_bit_cnt;
   logic [2:0]      w_bit_cnt_next;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_next;
   logic            r_parity_ok;
   logic            w_parity_ok_next;
   logic [TmoW-1:0] r_tmo_cnt;
   logic [TmoW-1:0] w_tmo_next;
   logic            w_good;
   logic            w_err_next;

   logic            r_valid;
   logic            w_valid_next;
   logic [7:0]      r_byte;
   logic [7:0]      w_byte_next;
   logic            r_frame_error;
   logic            r_overrun;
   logic            w_ovr_next;
   logic            w_take;

   ps2_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_clk_filter (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_ps2_clk),
      .o_level (w_clk_level_unused),
      .o_fall  (w_clk_fall)
   );

   ps2_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_data_filter (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_line  (i_ps2_data),
      .o_level (w_data_level),
      .o_fall  (w_data_fall_unused)
   );

   always_comb begin
      w_state_next     = r_state;
      w_bit_cnt_next   = r_bit_cnt;
      w_shift_next     = r_shift;
      w_parity_ok_next = r_parity_ok;
      w_tmo_next       = r_tmo_cnt;
      w_good           = 1'b0;
      w_err_next       = 1'b0;
      if (!i_enable) begin
         w_state_next   = StIdle;
         w_bit_cnt_next = '0;
         w_tmo_next     = '0;
      end else if (w_clk_fall) begin
         w_tmo_next = '0;
         case (r_state)
            StIdle: begin
               if (!w_data_level) begin
                  w_state_next   = StData;
                  w_bit_cnt_next = '0;
               end
            end
            StData: begin
               w_shift_next   = {w_data_level, r_shift[7:1]};
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_state_next = StParity;
               end
            end
            StParity: begin
               w_parity_ok_next = ^{r_shift, w_data_level};
               w_state_next     = StStop;
            end
            StStop: begin
               w_state_next = StIdle;
               if (w_data_level && r_parity_ok) begin
                  w_good = 1'b1;
               end else begin
                  w_err_next = 1'b1;
               end
            end
            default: w_state_next = StIdle;
         endcase
      end else if (r_state != StIdle) begin
         if (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES)) begin
            w_state_next = StIdle;
            w_tmo_next   = '0;
            w_err_next   = 1'b1;
         end else begin
            w_tmo_next = r_tmo_cnt + 1'b1;
         end
      end
   end

   // A byte taken in the same cycle frees the buffer for the incoming frame.
   assign w_take = r_valid & i_scan_code_ready;

   always_comb begin
      w_valid_next = r_valid;
      w_byte_next  = r_byte;
      w_ovr_next   = 1'b0;
      if (w_good) begin
         if (!r_valid || w_take) begin
            w_valid_next = 1'b1;
            w_byte_next  = r_shift;
         end else begin
            w_ovr_next = 1'b1;
         end
      end else if (w_take) begin
         w_valid_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_parity_ok   <= 1'b0;
         r_tmo_cnt     <= '0;
         r_valid       <= 1'b0;
         r_byte        <= '0;
         r_frame_error <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_bit_cnt     <= w_bit_cnt_next;
         r_shift       <= w_shift_next;
         r_parity_ok   <= w_parity_ok_next;
         r_tmo_cnt     <= w_tmo_next;
         r_valid       <= w_valid_next;
         r_byte        <= w_byte_next;
         r_frame_error <= w_err_next;
         r_overrun     <= w_ovr_next;
      end
   end

   assign o_scan_code_valid = r_valid;
   assign o_scan_code_byte  = r_byte;
   assign o_frame_error     = r_frame_error;
   assign o_overrun         = r_overrun;
   assign o_busy            = (r_state != StIdle);

endmodule
